// File: rtl/vsensor_if.sv
// Sensor-side bus of the voltage sensor macro: enable/calibration/offset
// toward the sensor, sample and calibration strobes back from it.
interface vsensor_if;
  logic       sen_en;
  logic       sen_calib;
  logic [9:0] sen_offset;
  logic       sen_valid;
  logic       sen_calib_done;
  logic [9:0] sen_data;

  modport master (
    output sen_en, sen_calib, sen_offset,
    input  sen_valid, sen_calib_done, sen_data
  );

  modport slave (
    input  sen_en, sen_calib, sen_offset,
    output sen_valid, sen_calib_done, sen_data
  );
endinterface

// File: rtl/vsensor_ctrl.sv
// Voltage sensor sequencer: calibrate once, then repeat interval-gated
// conversion bursts, average each burst and check it against a window.
module vsensor_ctrl #(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [9:0]       cfg_offset,
  input  logic [15:0]      cfg_interval,
  input  logic [9:0]       cfg_thresh_lo,
  input  logic [9:0]       cfg_thresh_hi,
  vsensor_if.master        sen,
  output logic             avg_valid,
  output logic [9:0]       avg_data,
  output logic             alarm_lo,
  output logic             alarm_hi,
  output logic             err_timeout,
  output logic             busy
);

  localparam int NS    = 1 << AVG_LOG2;
  localparam int ACC_W = 10 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALIB, S_WAIT, S_CONV, S_ERR} state_e;

  function automatic logic [9:0] avg_trunc(input logic [ACC_W-1:0] sum);
    avg_trunc = 10'(sum >> AVG_LOG2);
  endfunction

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        int_cnt_q, int_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               sen_en_q, sen_en_d;
  logic               sen_calib_q, sen_calib_d;
  logic [9:0]         sen_offset_q, sen_offset_d;
  logic               avg_valid_q, avg_valid_d;
  logic [9:0]         avg_data_q, avg_data_d;
  logic               alarm_lo_q, alarm_lo_d;
  logic               alarm_hi_q, alarm_hi_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [ACC_W-1:0]   sum;
  logic               tmo_exp;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    int_cnt_d    = int_cnt_q;
    tmo_d        = tmo_q;
    sen_offset_d = sen_offset_q;
    avg_valid_d  = 1'b0;
    avg_data_d   = avg_data_q;
    alarm_lo_d   = alarm_lo_q;
    alarm_hi_d   = alarm_hi_q;
    err_d        = err_q;
    sum          = acc_q + ACC_W'(sen.sen_data);
    tmo_exp      = (tmo_q == TMO_LAST);

    if (stop && state_q != S_IDLE) begin
      // Abort: partial burst is dropped, results and sticky flags kept
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_d      = S_CALIB;
            sen_offset_d = cfg_offset;
            alarm_lo_d   = 1'b0;
            alarm_hi_d   = 1'b0;
            err_d        = 1'b0;
            acc_d        = '0;
            cnt_d        = '0;
            tmo_d        = '0;
          end
        end
        S_CALIB: begin
          if (sen.sen_calib_done) begin
            state_d   = S_WAIT;
            int_cnt_d = cfg_interval;
          end else if (tmo_exp) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        S_WAIT: begin
          if (int_cnt_q == '0) begin
            state_d = S_CONV;
            tmo_d   = '0;
          end else begin
            int_cnt_d = int_cnt_q - 16'd1;
          end
        end
        S_CONV: begin
          // An event in the expiry cycle wins over the timeout
          if (sen.sen_valid) begin
            tmo_d = '0;
            if (cnt_q == CNT_LAST) begin
              avg_data_d  = avg_trunc(sum);
              avg_valid_d = 1'b1;
              if (avg_trunc(sum) < cfg_thresh_lo) alarm_lo_d = 1'b1;
              if (avg_trunc(sum) > cfg_thresh_hi) alarm_hi_d = 1'b1;
              acc_d     = '0;
              cnt_d     = '0;
              state_d   = S_WAIT;
              int_cnt_d = cfg_interval;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (tmo_exp) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    sen_en_d    = (state_d == S_CALIB) || (state_d == S_CONV);
    sen_calib_d = (state_d == S_CALIB);
    busy_d      = (state_d == S_CALIB) || (state_d == S_WAIT) || (state_d == S_CONV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      int_cnt_q    <= '0;
      tmo_q        <= '0;
      sen_en_q     <= 1'b0;
      sen_calib_q  <= 1'b0;
      sen_offset_q <= '0;
      avg_valid_q  <= 1'b0;
      avg_data_q   <= '0;
      alarm_lo_q   <= 1'b0;
      alarm_hi_q   <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      int_cnt_q    <= int_cnt_d;
      tmo_q        <= tmo_d;
      sen_en_q     <= sen_en_d;
      sen_calib_q  <= sen_calib_d;
      sen_offset_q <= sen_offset_d;
      avg_valid_q  <= avg_valid_d;
      avg_data_q   <= avg_data_d;
      alarm_lo_q   <= alarm_lo_d;
      alarm_hi_q   <= alarm_hi_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign sen.sen_en     = sen_en_q;
  assign sen.sen_calib  = sen_calib_q;
  assign sen.sen_offset = sen_offset_q;
  assign avg_valid      = avg_valid_q;
  assign avg_data       = avg_data_q;
  assign alarm_lo       = alarm_lo_q;
  assign alarm_hi       = alarm_hi_q;
  assign err_timeout    = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vsensor_ctrl.sv
// Directed bench for vsensor_ctrl: burst table plus hand-written sequences
// for calibration/wait timing, timeout, stop and reset.
module tb_vsensor_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [9:0]  cfg_offset;
  logic [15:0] cfg_interval;
  logic [9:0]  cfg_thresh_lo;
  logic [9:0]  cfg_thresh_hi;
  logic        avg_valid;
  logic [9:0]  avg_data;
  logic        alarm_lo;
  logic        alarm_hi;
  logic        err_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vsensor_if sif ();

  vsensor_ctrl #(.AVG_LOG2(2), .TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .cfg_offset    (cfg_offset),
    .cfg_interval  (cfg_interval),
    .cfg_thresh_lo (cfg_thresh_lo),
    .cfg_thresh_hi (cfg_thresh_hi),
    .sen           (sif),
    .avg_valid     (avg_valid),
    .avg_data      (avg_data),
    .alarm_lo      (alarm_lo),
    .alarm_hi      (alarm_hi),
    .err_timeout   (err_timeout),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][9:0] smp;
    logic [9:0]      lo;
    logic [9:0]      hi;
    logic [9:0]      ea;
    logic            elo;
    logic            ehi;
  } vec_t;

  vec_t tbl [5];

  function automatic vec_t mk(input logic [9:0] a, b, c, d, lo, hi, ea,
                              input logic elo, ehi);
    vec_t v;
    v.smp[0] = a; v.smp[1] = b; v.smp[2] = c; v.smp[3] = d;
    v.lo = lo; v.hi = hi; v.ea = ea; v.elo = elo; v.ehi = ehi;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_conv(input string nm);
    for (int i = 0; i < 40 && !sif.sen_en; i++) tick();
    chk(nm, sif.sen_en, 1);
  endtask

  task automatic do_burst(input vec_t v, input string nm);
    cfg_thresh_lo = v.lo;
    cfg_thresh_hi = v.hi;
    for (int i = 0; i < 4; i++) begin
      sif.sen_valid = 1'b1;
      sif.sen_data  = v.smp[i];
      tick();
      if (i < 3) chk({nm, "_no_early_valid"}, avg_valid, 0);
    end
    sif.sen_valid = 1'b0;
    chk({nm, "_avg_valid"}, avg_valid, 1);
    chk({nm, "_avg_data"}, avg_data, v.ea);
    chk({nm, "_alarm_lo"}, alarm_lo, v.elo);
    chk({nm, "_alarm_hi"}, alarm_hi, v.ehi);
    chk({nm, "_wait_sen_en"}, sif.sen_en, 0);
    tick();
    chk({nm, "_single_pulse"}, avg_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_offset = 10'h155; cfg_interval = 16'd3;
    cfg_thresh_lo = 10'd0; cfg_thresh_hi = 10'd1023;
    sif.sen_valid = 1'b0; sif.sen_calib_done = 1'b0; sif.sen_data = '0;

    tbl[0] = mk(100, 101, 102, 104, 0, 1023, 101, 0, 0);
    tbl[1] = mk(200, 200, 200, 203, 200, 200, 200, 0, 0);
    tbl[2] = mk(150, 150, 150, 150, 200, 300, 150, 1, 0);
    tbl[3] = mk(350, 350, 350, 350, 200, 300, 350, 1, 1);
    tbl[4] = mk(1023, 1023, 1023, 1022, 0, 1023, 1022, 1, 1);

    tick(); tick();
    rst = 1'b0;
    chk("reset_outputs", {sif.sen_en, sif.sen_calib, sif.sen_offset, avg_valid,
                          avg_data, alarm_lo, alarm_hi, err_timeout, busy}, 0);

    // Start, calibration held 5 cycles, WAIT of interval 3
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_sen_en", sif.sen_en, 1);
    chk("start_offset", sif.sen_offset, 10'h155);
    for (int i = 0; i < 5; i++) begin
      chk("calib_high", sif.sen_calib, 1);
      if (i == 4) sif.sen_calib_done = 1'b1;
      tick();
    end
    sif.sen_calib_done = 1'b0;
    chk("calib_released", sif.sen_calib, 0);
    for (int i = 0; i < 4; i++) begin
      chk("wait_sen_en_low", sif.sen_en, 0);
      tick();
    end
    chk("conv_after_wait", sif.sen_en, 1);

    for (int r = 0; r < 5; r++) begin
      do_burst(tbl[r], $sformatf("burst%0d", r));
      wait_conv($sformatf("burst%0d_next_conv", r));
    end

    // start while busy is ignored
    cfg_offset = 10'h2AA;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_calib", sif.sen_calib, 0);
    chk("busy_start_offset", sif.sen_offset, 10'h155);
    chk("busy_start_alarm", alarm_lo, 1);

    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_sen_en", sif.sen_en, 0);
    chk("stop_hold_alarm_hi", alarm_hi, 1);
    chk("stop_hold_avg", avg_data, 1022);

    // New session clears sticky flags, then times out in CONV
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_clear_alarms", {alarm_lo, alarm_hi}, 0);
    chk("restart_offset", sif.sen_offset, 10'h2AA);
    tick();
    sif.sen_calib_done = 1'b1; tick(); sif.sen_calib_done = 1'b0;
    wait_conv("tmo_conv");
    for (int i = 0; i < 2; i++) begin
      sif.sen_valid = 1'b1; sif.sen_data = 10'd500; tick();
    end
    sif.sen_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("tmo_still_busy", {busy, err_timeout, avg_valid}, 3'b100);
      tick();
    end
    chk("tmo_err", err_timeout, 1);
    chk("tmo_idle_outputs", {busy, sif.sen_en, avg_valid}, 0);

    // Recovery; calib_done lands exactly in the expiry cycle
    start = 1'b1; tick(); start = 1'b0;
    chk("recover_calib", sif.sen_calib, 1);
    chk("recover_err_clear", err_timeout, 0);
    for (int i = 0; i < 15; i++) tick();
    sif.sen_calib_done = 1'b1; tick(); sif.sen_calib_done = 1'b0;
    chk("edge_event_no_err", {err_timeout, busy, sif.sen_calib}, 3'b010);

    // stop coinciding with the 4th sample
    wait_conv("stop_conv");
    for (int i = 0; i < 3; i++) begin
      sif.sen_valid = 1'b1; sif.sen_data = 10'd10 * 10'(i + 1); tick();
    end
    sif.sen_data = 10'd40; stop = 1'b1; tick();
    sif.sen_valid = 1'b0; stop = 1'b0;
    chk("stop4_no_valid", avg_valid, 0);
    chk("stop4_idle", busy, 0);
    chk("stop4_avg_held", avg_data, 1022);
    tick();
    chk("stop4_no_late_valid", avg_valid, 0);

    // Fresh session with zero interval; average uses only new samples
    cfg_interval = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    sif.sen_calib_done = 1'b1; tick(); sif.sen_calib_done = 1'b0;
    chk("wait0_low", sif.sen_en, 0);
    tick();
    chk("wait0_conv", sif.sen_en, 1);
    do_burst(mk(40, 40, 40, 44, 0, 1023, 41, 0, 0), "fresh");

    // Reset in CONV with a competing start
    wait_conv("rst_conv");
    for (int i = 0; i < 2; i++) begin
      sif.sen_valid = 1'b1; sif.sen_data = 10'd77; tick();
    end
    sif.sen_valid = 1'b0;
    rst = 1'b1; start = 1'b1; tick();
    chk("rst_outputs", {sif.sen_en, sif.sen_calib, sif.sen_offset, avg_valid,
                        avg_data, alarm_lo, alarm_hi, err_timeout, busy}, 0);
    tick();
    chk("rst_start_ignored", {busy, sif.sen_calib}, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
